spi_sub: RTL and testbench
==========================

SPI_SUB -- requirements
Module: spi_sub

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on i_sclk, i_cs_n and i_mosi (minimum 2).
REQ-002 SHALL have port i_clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port i_mode, input, 2, SPI mode 0..3 (CPOL = bit1, CPHA = bit0).
REQ-005 SHALL have ports i_sclk, i_cs_n and i_mosi, each input, 1, the raw SPI bus from the main.
REQ-006 SHALL have port o_miso, output, 1, the serial reply to the main.
REQ-007 SHALL have ports i_tx_byte (input, 8), i_tx_valid (input, 1) and o_tx_ready (output, 1), the reply-byte valid/ready handshake.
REQ-008 SHALL have ports o_rx_byte (output, 8) and o_rx_valid (output, 1), the received byte and its 1-cycle strobe.
REQ-009 SHALL have outputs o_busy, o_underrun and o_abort, each 1 bit: frame active, underrun pulse and aborted-frame pulse.

Function
REQ-010 SHALL pass i_sclk, i_cs_n and i_mosi through SYNC_STAGES flops and detect SCLK edges from the last two synchronized samples; i_clk SHALL be at least 4x SCLK.
REQ-011 SHALL transfer LSB first, 8 bits per byte, with any number of consecutive bytes per CS-low frame.
REQ-012 SHALL latch i_mode only while synchronized CS is high; mode changes while CS is low SHALL be ignored until the frame ends.
REQ-013 SHALL define sample edge = rising for modes 0 and 3 and falling for modes 1 and 2; shift edge = the opposite edge.
REQ-014 SHALL implement FSM IDLE, ACTIVE: IDLE->ACTIVE on synchronized CS fall; ACTIVE->IDLE on synchronized CS rise; o_busy = (state == ACTIVE).
REQ-015 SHALL sample synchronized MOSI into bit position bit_cnt on each sample edge in ACTIVE; bit_cnt is 3 bits and wraps 7->0.
REQ-016 SHALL, on the 8th sample edge, update o_rx_byte and pulse o_rx_valid high for exactly one i_clk, the cycle after the edge-detect cycle.
REQ-017 SHALL accept a byte into a 1-entry holding register when i_tx_valid && o_tx_ready; o_tx_ready = holding register empty.
REQ-018 SHALL load the shift register at each byte start from the holding register (marking it empty) or, if it is empty, with 8'hFF plus a 1-cycle o_underrun pulse.
REQ-019 SHALL define byte start for CPHA=0 as the CS-fall detect cycle or the first shift edge after the 8th sample edge, with bit0 driven immediately; for CPHA=1, byte start is the first shift edge of each byte, with bit0 driven on it.
REQ-020 SHALL drive each later bit on the next shift edge.
REQ-021 SHALL, when a handshake write and a byte-start load occur in the same cycle, load from the holding content before that cycle; the new byte is kept for the next byte start.
REQ-022 SHALL, on CS rise with bit_cnt != 0, discard the partial byte, produce no o_rx_valid, pulse o_abort for one cycle and clear bit_cnt; the holding register is retained.
REQ-023 SHALL drive o_miso to 0 in IDLE.
REQ-024 SHALL ignore SCLK edges in IDLE.

Reset
REQ-025 SHALL, while i_rst_n is low, asynchronously force: state IDLE, latched mode 0, bit_cnt 0, holding empty, synchronizer flops 1 for CS and 0 for SCLK/MOSI, o_miso 0, o_tx_ready 1, o_rx_byte 8'h00, o_rx_valid 0, o_busy 0, o_underrun 0, o_abort 0.
REQ-026 SHALL, on reset mid-frame, drop the partial byte and require a fresh CS fall after reset release before any transfer.

Structure
REQ-027 SHALL place mode constants MODE0..MODE3 and the FSM state encoding in shared package spi_pkg.
REQ-028 SHALL implement the synchronizer as sub-module spi_sync (parameterised depth, reset value input), instantiated three times.

Verification
REQ-029 SHALL cover mode 0, SCLK = i_clk/8: holding 8'hA5, main sends 8'h3C -> o_rx_byte 8'h3C with one o_rx_valid pulse; MISO bits 1,0,1,0,0,1,0,1.
REQ-030 SHALL cover mode 3, two-byte frame, holding 8'h81 then 8'h7E written after o_tx_ready: main sends 8'h12, 8'h34 -> two o_rx_valid pulses (8'h12, 8'h34); MISO returns 8'h81, 8'h7E.
REQ-031 SHALL cover mode 1 with no i_tx_valid: main sends 8'hF0 -> o_underrun pulse at byte start, MISO returns 8'hFF, o_rx_byte 8'hF0.
REQ-032 SHALL cover mode 2 with CS raised after 5 sample edges -> no o_rx_valid, one o_abort pulse; next full frame receiving 8'h55 gives o_rx_byte 8'h55.
REQ-033 SHALL cover i_mode changed 0->3 while CS is low -> current frame completes in mode 0; the next frame uses mode 3.
REQ-034 SHALL cover i_rst_n asserted after 3 bits -> all outputs at reset values; a subsequent frame receiving 8'hC3 completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI subordinate definitions: mode constants, FSM encoding and the
// sample-edge polarity rule.
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'd0;
   localparam logic [1:0] MODE1 = 2'd1;
   localparam logic [1:0] MODE2 = 2'd2;
   localparam logic [1:0] MODE3 = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling.
   function automatic logic sample_on_rise(input logic [1:0] mode);
      case (mode)
         MODE0, MODE3: return 1'b1;
         MODE1, MODE2: return 1'b0;
         default:      return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous bus line, with a selectable
// reset level so idle-high and idle-low lines both come out of reset quiet.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_rst_val,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= {STAGES{i_rst_val}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_sub.sv
// SPI subordinate, modes 0..3, LSB first, oversampled SCLK in the i_clk domain,
// with a one-entry reply holding register and rx/underrun/abort strobes.
module spi_sub
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_mode,
   input  logic       i_sclk,
   input  logic       i_cs_n,
   input  logic       i_mosi,
   output logic       o_miso,
   input  logic [7:0] i_tx_byte,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_valid,
   output logic       o_busy,
   output logic       o_underrun,
   output logic       o_abort
);

   logic sclk_p0, cs_p0, mosi_p0;
   logic sclk_p1, cs_p1;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rst_val(1'b0), .i_d(i_sclk), .o_q(sclk_p0)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rst_val(1'b1), .i_d(i_cs_n), .o_q(cs_p0)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rst_val(1'b0), .i_d(i_mosi), .o_q(mosi_p0)
   );

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   armed;
   logic [1:0]             mode_q;
   logic [2:0]             bit_cnt;
   logic                   hold_full;
   logic [7:0]             hold_q;
   logic [6:0]             tx_sr;
   logic [6:0]             rx_sr;

   logic active, cpha, samp_rise;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic sample_edge, shift_edge, byte_start, byte_done, tx_accept;
   logic [7:0] load_val;

   // A CS fall only counts once CS has been seen high after reset, so a frame
   // cut by reset cannot resume mid-byte when reset is released.
   assign active      = (state_q == ST_ACTIVE);
   assign cpha        = mode_q[0];
   assign samp_rise   = sample_on_rise(mode_q);
   assign sclk_rise   = sclk_p0 & ~sclk_p1;
   assign sclk_fall   = ~sclk_p0 & sclk_p1;
   assign cs_rise     = cs_p0 & ~cs_p1;
   assign cs_fall     = armed & ~cs_p0 & cs_p1;
   assign sample_edge = active & ~cs_rise & (samp_rise ? sclk_rise : sclk_fall);
   assign shift_edge  = active & ~cs_rise & (samp_rise ? sclk_fall : sclk_rise);
   assign byte_start  = (cs_fall & ~active & ~cpha) | (shift_edge & (bit_cnt == 3'd0));
   assign byte_done   = sample_edge & (bit_cnt == 3'd7);
   assign tx_accept   = i_tx_valid & ~hold_full;
   assign load_val    = hold_full ? hold_q : 8'hFF;

   assign o_tx_ready  = ~hold_full;
   assign o_busy      = active;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
         ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sclk_p1    <= 1'b0;
         cs_p1      <= 1'b1;
         flush_q    <= '0;
         armed      <= 1'b0;
         mode_q     <= MODE0;
         bit_cnt    <= 3'd0;
         hold_full  <= 1'b0;
         o_miso     <= 1'b0;
         o_rx_byte  <= 8'h00;
         o_rx_valid <= 1'b0;
         o_underrun <= 1'b0;
         o_abort    <= 1'b0;
      end else begin
         sclk_p1 <= sclk_p0;
         cs_p1   <= cs_p0;
         flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         if (flush_q[SYNC_STAGES-1] && cs_p0) armed <= 1'b1;
         if (cs_p0) mode_q <= i_mode;

         if (cs_rise)          bit_cnt <= 3'd0;
         else if (sample_edge) bit_cnt <= bit_cnt + 3'd1;

         o_rx_valid <= byte_done;
         if (byte_done) o_rx_byte <= {mosi_p0, rx_sr};
         o_abort    <= cs_rise & active & (bit_cnt != 3'd0);
         o_underrun <= byte_start & ~hold_full;

         // A write landing on a load cycle fills the now-empty register.
         if (byte_start && hold_full) hold_full <= 1'b0;
         else if (tx_accept)          hold_full <= 1'b1;

         if (byte_start)              o_miso <= load_val[0];
         else if (shift_edge)         o_miso <= tx_sr[0];
         else if (state_d == ST_IDLE) o_miso <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (tx_accept) hold_q <= i_tx_byte;
      if (sample_edge && (bit_cnt != 3'd7)) rx_sr[bit_cnt] <= mosi_p0;
      if (byte_start)      tx_sr <= load_val[7:1];
      else if (shift_edge) tx_sr <= {1'b0, tx_sr[6:1]};
   end

endmodule

// File: tb/tb_spi_sub.sv
// Bench for spi_sub: a behavioural SPI main plus a byte-level model of the
// holding register, reply bytes, received bytes and strobe counts.
module tb_spi_sub;

   localparam int H = 4;  // SCLK half period in i_clk cycles (SCLK = i_clk/8)

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic [1:0] i_mode = 2'd0;
   logic       i_sclk = 1'b0;
   logic       i_cs_n = 1'b1;
   logic       i_mosi = 1'b0;
   logic [7:0] i_tx_byte = 8'h00;
   logic       i_tx_valid = 1'b0;
   logic       o_miso, o_tx_ready, o_rx_valid, o_busy, o_underrun, o_abort;
   logic [7:0] o_rx_byte;

   spi_sub #(.SYNC_STAGES(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode),
      .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi), .o_miso(o_miso),
      .i_tx_byte(i_tx_byte), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
      .o_rx_byte(o_rx_byte), .o_rx_valid(o_rx_valid),
      .o_busy(o_busy), .o_underrun(o_underrun), .o_abort(o_abort)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   // Byte-level model
   bit         m_full = 1'b0;
   logic [7:0] m_hold = 8'h00;
   int         exp_under = 0, act_under = 0;
   int         exp_abort = 0, act_abort = 0;
   int         n_rxv = 0;
   logic [7:0] last_rx = 8'h00;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[5];
   logic [7:0] got_miso[5];
   logic [7:0] fr_data[5];

   task automatic model_byte_start(input int idx);
      exp_tx[idx] = m_full ? m_hold : 8'hFF;
      if (!m_full) exp_under++;
      m_full = 1'b0;
   endtask

   // Compare process: every received strobe against the model queue, idle MISO.
   logic prev_rxv = 1'b0;
   always @(negedge i_clk) begin
      if (o_rx_valid) begin
         check("rx_valid_width", prev_rxv, 0);
         if (exp_rx.size() == 0) begin
            n_checks++;
            $display("FAIL rx_unexpected: strobe with byte 0x%0h, want no strobe", o_rx_byte);
         end else begin
            check("rx_byte", o_rx_byte, exp_rx.pop_front());
         end
         last_rx = o_rx_byte;
         n_rxv++;
      end
      if (!o_busy) check("miso_idle", o_miso, 0);
      if (o_underrun) act_under++;
      if (o_abort) act_abort++;
      prev_rxv = o_rx_valid;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   task automatic half();
      repeat (H) @(negedge i_clk);
   endtask

   task automatic tx_write(input logic [7:0] v);
      check("tx_ready", o_tx_ready, !m_full);
      @(negedge i_clk);
      i_tx_byte  = v;
      i_tx_valid = 1'b1;
      @(negedge i_clk);
      i_tx_valid = 1'b0;
      m_hold = v;
      m_full = 1'b1;
   endtask

   task automatic gap(input int j, input int b, input int wr_byte, input logic [7:0] wr_val);
      if (j == wr_byte && b == 3 && !m_full) begin
         tx_write(wr_val);
         repeat (H - 2) @(negedge i_clk);
      end else begin
         half();
      end
   endtask

   task automatic byte_fin(input int j, input logic [7:0] mb);
      got_miso[j] = mb;
      check("miso_byte", mb, exp_tx[j]);
      exp_rx.push_back(fr_data[j]);
   endtask

   task automatic spi_frame(input logic [1:0] md, input int nbits, input int wr_byte,
                            input logic [7:0] wr_val, input int new_mode, input bit keep_cs);
      int j, b;
      logic [7:0] mb;
      mb = 8'h00;
      i_mode = md;
      i_sclk = md[1];
      repeat (6) @(negedge i_clk);
      i_cs_n = 1'b0;
      if (!md[0]) begin
         model_byte_start(0);
         i_mosi = fr_data[0][0];
      end
      half();
      if (new_mode >= 0) i_mode = 2'(new_mode);
      check("busy_in_frame", o_busy, 1);
      for (int k = 0; k < nbits; k++) begin
         j = k / 8;
         b = k % 8;
         if (md[0]) begin
            i_sclk = ~i_sclk;
            if (b == 0) model_byte_start(j);
            i_mosi = fr_data[j][b];
            half();
            mb[b] = o_miso;
            i_sclk = ~i_sclk;
            if (b == 7) byte_fin(j, mb);
            gap(j, b, wr_byte, wr_val);
         end else begin
            mb[b] = o_miso;
            i_sclk = ~i_sclk;
            if (b == 7) byte_fin(j, mb);
            gap(j, b, wr_byte, wr_val);
            i_sclk = ~i_sclk;
            if (b == 7) model_byte_start(j + 1);
            i_mosi = fr_data[(k + 1) / 8][(k + 1) % 8];
            half();
         end
      end
      if (!keep_cs) begin
         i_cs_n = 1'b1;
         if (nbits % 8 != 0) exp_abort++;
         repeat (10) @(negedge i_clk);
      end
   endtask

   task automatic frame_end_checks();
      check("underrun_count", act_under, exp_under);
      check("abort_count", act_abort, exp_abort);
      check("rx_pending", exp_rx.size(), 0);
      check("tx_ready_end", o_tx_ready, !m_full);
      check("busy_end", o_busy, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_miso", o_miso, 0);
      check("rst_tx_ready", o_tx_ready, 1);
      check("rst_rx_byte", o_rx_byte, 8'h00);
      check("rst_rx_valid", o_rx_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_underrun", o_underrun, 0);
      check("rst_abort", o_abort, 0);
   endtask

   initial begin
      int n0, u0, a0, nb, nbits, wb;
      logic [1:0] md;

      repeat (3) @(negedge i_clk);
      check_reset_outputs();
      i_rst_n = 1'b1;
      repeat (5) @(negedge i_clk);

      // Mode 0, holding A5, main sends 3C
      tx_write(8'hA5);
      fr_data[0] = 8'h3C;
      n0 = n_rxv;
      spi_frame(2'd0, 8, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("m0_miso_literal", got_miso[0], 8'hA5);
      check("m0_rx_literal", last_rx, 8'h3C);
      check("m0_rx_pulses", n_rxv - n0, 1);

      // Mode 3, two bytes, 81 preloaded, 7E written once ready
      tx_write(8'h81);
      fr_data[0] = 8'h12;
      fr_data[1] = 8'h34;
      n0 = n_rxv;
      spi_frame(2'd3, 16, 0, 8'h7E, -1, 1'b0);
      frame_end_checks();
      check("m3_miso0_literal", got_miso[0], 8'h81);
      check("m3_miso1_literal", got_miso[1], 8'h7E);
      check("m3_rx_literal", last_rx, 8'h34);
      check("m3_rx_pulses", n_rxv - n0, 2);

      // Mode 1, nothing to send: underrun and FF reply
      fr_data[0] = 8'hF0;
      u0 = act_under;
      spi_frame(2'd1, 8, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("m1_miso_literal", got_miso[0], 8'hFF);
      check("m1_rx_literal", last_rx, 8'hF0);
      check("m1_underrun_pulses", act_under - u0, 1);

      // Mode 2, CS raised after 5 sample edges, then a full frame
      fr_data[0] = 8'h99;
      n0 = n_rxv;
      a0 = act_abort;
      spi_frame(2'd2, 5, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("m2_abort_pulses", act_abort - a0, 1);
      check("m2_abort_no_rx", n_rxv - n0, 0);
      fr_data[0] = 8'h55;
      spi_frame(2'd2, 8, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("m2_rx_literal", last_rx, 8'h55);

      // Mode changed 0->3 while CS low; next frame in mode 3
      tx_write(8'hC6);
      fr_data[0] = 8'h5A;
      spi_frame(2'd0, 8, -1, 8'h00, 3, 1'b0);
      frame_end_checks();
      check("mchg_rx_literal", last_rx, 8'h5A);
      check("mchg_miso_literal", got_miso[0], 8'hC6);
      fr_data[0] = 8'h6B;
      spi_frame(2'd3, 8, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("mchg_next_rx_literal", last_rx, 8'h6B);

      // Reset after 3 bits with CS still low
      fr_data[0] = 8'hE7;
      spi_frame(2'd0, 3, -1, 8'h00, -1, 1'b1);
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs();
      m_full = 1'b0;
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (8) @(negedge i_clk);
      for (int t = 0; t < 4; t++) begin
         i_sclk = ~i_sclk;
         half();
      end
      check("rst_no_resume_busy", o_busy, 0);
      i_cs_n = 1'b1;
      repeat (6) @(negedge i_clk);
      fr_data[0] = 8'hC3;
      spi_frame(2'd0, 8, -1, 8'h00, -1, 1'b0);
      frame_end_checks();
      check("rst_next_rx_literal", last_rx, 8'hC3);

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         md = 2'($urandom_range(0, 3));
         nb = $urandom_range(1, 3);
         for (int i = 0; i < 5; i++) fr_data[i] = 8'($urandom);
         if ($urandom_range(0, 1) == 1 && !m_full) tx_write(8'($urandom));
         nbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nb * 8 - 1) : nb * 8;
         wb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nb - 1) : -1;
         spi_frame(md, nbits, wb, 8'($urandom), -1, 1'b0);
         frame_end_checks();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
